hv_mem_server: RTL and testbench

Per-modality memory responder that serves item-memory (iM), negative-projection (projM_neg) and positive-projection (projM_pos) hypervector rows to one modality port of the spatial encoder. It accepts the encoder's channel address with a ready/valid handshake and drives one sync-read SRAM macro per matrix. After each consumed row it prefetches the next address, so it sustains one row per cycle. It also provides the write port used at initialisation to load the three matrices. One instance is built per modality.

---
 rtl/hv_mem_server.sv | 140 ++++++++++++++
 tb/tb_hv_mem_server.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_mem_server.sv
// hv_mem_server: per-modality responder serving iM / projM_neg / projM_pos rows
// from three sync-read SRAM macros. A one-entry tag tracks which row currently
// sits on the macro read outputs. Each consumed row prefetches the next row, so
// a sequential stream is served at one row per cycle. The shared write port
// loads the matrices during initialisation.
module hv_mem_server #(
    parameter int unsigned HV_DIMENSION = 2000,
    parameter int unsigned NUM_ROWS     = 32,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    // encoder request port
    input  logic                    ReqValid_SI,
    input  logic                    ReqReady_SI,
    input  logic [ADDR_WIDTH-1:0]   ReqAddr_DI,
    output logic                    RespValid_SO,
    output logic [HV_DIMENSION-1:0] ImData_DO,
    output logic [HV_DIMENSION-1:0] ProjNeg_DO,
    output logic [HV_DIMENSION-1:0] ProjPos_DO,
    // initialisation load port
    input  logic                    LoadValid_SI,
    output logic                    LoadReady_SO,
    input  logic [1:0]              LoadSel_DI,
    input  logic [ADDR_WIDTH-1:0]   LoadAddr_DI,
    input  logic [HV_DIMENSION-1:0] LoadData_DI,
    // SRAM macro port
    output logic                    Sram_CE_SO,
    output logic [2:0]              Sram_WE_SO,
    output logic [ADDR_WIDTH-1:0]   Sram_Addr_DO,
    output logic [HV_DIMENSION-1:0] Sram_WData_DO,
    input  logic [HV_DIMENSION-1:0] Sram_RData0_DI,
    input  logic [HV_DIMENSION-1:0] Sram_RData1_DI,
    input  logic [HV_DIMENSION-1:0] Sram_RData2_DI,
    // error flag
    output logic                    AddrErr_SO
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

    typedef enum logic {
        EMPTY,
        HIT
    } state_t;

    state_t                  State_SP;
    logic [ADDR_WIDTH-1:0]   Tag_SP;
    logic                    AddrErr_SP;

    logic                    req_in_range;
    logic                    load_in_range;
    logic                    consume;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    issue;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic                    do_write;

    assign req_in_range  = (ReqAddr_DI <= LAST_ROW);
    assign load_in_range = (LoadAddr_DI <= LAST_ROW);
    assign next_addr     = (Tag_SP == LAST_ROW) ? '0 : Tag_SP + ADDR_WIDTH'(1);

    // Row data comes straight from the macros; the tag says which row it is.
    assign ImData_DO  = Sram_RData0_DI;
    assign ProjNeg_DO = Sram_RData1_DI;
    assign ProjPos_DO = Sram_RData2_DI;

    assign RespValid_SO = Reset_RBI & (State_SP == HIT) & ReqValid_SI & (ReqAddr_DI == Tag_SP);
    assign consume      = RespValid_SO & ReqReady_SI;
    assign LoadReady_SO = Reset_RBI & ~ReqValid_SI;
    assign AddrErr_SO   = AddrErr_SP;

    // Decide this cycle's macro access: prefetch, miss re-read, cold read or load write.
    // Reserved-select and out-of-range loads are handshaken but never touch the macros,
    // since a CE without WE would read and clobber the rows held on the outputs.
    always_comb begin
        issue      = 1'b0;
        issue_addr = '0;
        do_write   = 1'b0;
        if (Reset_RBI) begin
            if (State_SP == EMPTY) begin
                if (ReqValid_SI && req_in_range) begin
                    issue      = 1'b1;
                    issue_addr = ReqAddr_DI;
                end else if (!ReqValid_SI && LoadValid_SI && load_in_range && LoadSel_DI != 2'd3) begin
                    do_write = 1'b1;
                end
            end else begin
                if (consume) begin
                    issue      = 1'b1;
                    issue_addr = next_addr;
                end else if (ReqValid_SI && req_in_range && ReqAddr_DI != Tag_SP) begin
                    issue      = 1'b1;
                    issue_addr = ReqAddr_DI;
                end else if (!ReqValid_SI && LoadValid_SI && load_in_range && LoadSel_DI != 2'd3) begin
                    do_write = 1'b1;
                end
            end
        end
    end

    // Drive the shared macro port; address and data are zero when the macros are idle.
    always_comb begin
        Sram_CE_SO    = issue | do_write;
        Sram_WE_SO    = '0;
        Sram_Addr_DO  = '0;
        Sram_WData_DO = '0;
        if (issue) begin
            Sram_Addr_DO = issue_addr;
        end else if (do_write) begin
            Sram_Addr_DO  = LoadAddr_DI;
            Sram_WData_DO = LoadData_DI;
            case (LoadSel_DI)
                2'd0:    Sram_WE_SO = 3'b001;
                2'd1:    Sram_WE_SO = 3'b010;
                2'd2:    Sram_WE_SO = 3'b100;
                default: Sram_WE_SO = 3'b000;
            endcase
        end
    end

    // Tag/state tracking: any read-issue retags, any write invalidates; error is sticky.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            State_SP   <= EMPTY;
            Tag_SP     <= '0;
            AddrErr_SP <= 1'b0;
        end else begin
            if (ReqValid_SI && !req_in_range) begin
                AddrErr_SP <= 1'b1;
            end
            if (issue) begin
                Tag_SP   <= issue_addr;
                State_SP <= HIT;
            end else if (do_write) begin
                State_SP <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_hv_mem_server.sv
// Directed bench for hv_mem_server with a behavioural model of the three
// sync-read macros. Expected row contents come from the pat() function.
module tb_hv_mem_server;

    localparam int unsigned HVD = 64;
    localparam int unsigned NR  = 32;
    localparam int unsigned AW  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0, req_ready = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic           resp_valid;
    logic [HVD-1:0] im_d, neg_d, pos_d;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [1:0]     load_sel = '0;
    logic [AW-1:0]  load_addr = '0;
    logic [HVD-1:0] load_data = '0;
    logic           ce;
    logic [2:0]     we;
    logic [AW-1:0]  saddr;
    logic [HVD-1:0] wdata;
    logic [HVD-1:0] rd0, rd1, rd2;
    logic           addr_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [HVD-1:0] mem [0:2][0:NR-1];

    always #5 clk = ~clk;

    hv_mem_server #(
        .HV_DIMENSION(HVD),
        .NUM_ROWS    (NR),
        .ADDR_WIDTH  (AW)
    ) dut (
        .Clk_CI        (clk),
        .Reset_RBI     (rst_n),
        .ReqValid_SI   (req_valid),
        .ReqReady_SI   (req_ready),
        .ReqAddr_DI    (req_addr),
        .RespValid_SO  (resp_valid),
        .ImData_DO     (im_d),
        .ProjNeg_DO    (neg_d),
        .ProjPos_DO    (pos_d),
        .LoadValid_SI  (load_valid),
        .LoadReady_SO  (load_ready),
        .LoadSel_DI    (load_sel),
        .LoadAddr_DI   (load_addr),
        .LoadData_DI   (load_data),
        .Sram_CE_SO    (ce),
        .Sram_WE_SO    (we),
        .Sram_Addr_DO  (saddr),
        .Sram_WData_DO (wdata),
        .Sram_RData0_DI(rd0),
        .Sram_RData1_DI(rd1),
        .Sram_RData2_DI(rd2),
        .AddrErr_SO    (addr_err)
    );

    // Macro model: each macro shares CE/address, writes on its WE bit, reads otherwise.
    always @(posedge clk) begin
        if (ce && saddr < AW'(NR)) begin
            if (we[0]) mem[0][saddr[4:0]] <= wdata; else rd0 <= mem[0][saddr[4:0]];
            if (we[1]) mem[1][saddr[4:0]] <= wdata; else rd1 <= mem[1][saddr[4:0]];
            if (we[2]) mem[2][saddr[4:0]] <= wdata; else rd2 <= mem[2][saddr[4:0]];
        end
    end

    function automatic logic [HVD-1:0] pat(input int unsigned sel, input int unsigned row);
        return {32'(sel * 1000 + row + 1), 32'hC0DE_0000 ^ 32'(row << 4) ^ 32'(sel)};
    endfunction

    // Advance to the next cycle: past the edge, ready for new inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp got %b exp 0", resp_valid); end
        n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL reset_ce got %b exp 0", ce); end
        n_cmp++; if (we !== 3'b000) begin n_err++; $display("FAIL reset_we got %b exp 000", we); end
        n_cmp++; if (saddr !== '0) begin n_err++; $display("FAIL reset_addr got %0d exp 0", saddr); end
        n_cmp++; if (wdata !== '0) begin n_err++; $display("FAIL reset_wdata got %h exp 0", wdata); end
        n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", addr_err); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_load();
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < int'(NR); r++) begin
                load_valid = 1'b1;
                load_sel   = 2'(s);
                load_addr  = AW'(r);
                load_data  = pat(s, r);
                #1;
                n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready s%0d r%0d got %b exp 1", s, r, load_ready); end
                n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL load_ce s%0d r%0d got %b exp 1", s, r, ce); end
                n_cmp++; if (we !== 3'(1 << s)) begin n_err++; $display("FAIL load_we s%0d r%0d got %b exp %b", s, r, we, 3'(1 << s)); end
                n_cmp++; if (saddr !== AW'(r) || wdata !== pat(s, r)) begin n_err++; $display("FAIL load_port s%0d r%0d got %0d/%h exp %0d/%h", s, r, saddr, wdata, r, pat(s, r)); end
                cyc();
            end
        end
        load_sel  = 2'd3;
        load_addr = 8'd4;
        load_data = '1;
        #1;
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_sel3_ready got %b exp 1", load_ready); end
        n_cmp++; if (we !== 3'b000 || ce !== 1'b0) begin n_err++; $display("FAIL load_sel3_we got ce %b we %b exp ce 0 we 000", ce, we); end
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic test_stream();
        req_valid = 1'b1;
        req_ready = 1'b1;
        req_addr  = 8'd0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL stream_cold_resp got %b exp 0", resp_valid); end
        n_cmp++; if (ce !== 1'b1 || saddr !== 8'd0) begin n_err++; $display("FAIL stream_cold_issue got ce %b addr %0d exp ce 1 addr 0", ce, saddr); end
        cyc();
        for (int a = 0; a < int'(NR); a++) begin
            req_addr = AW'(a);
            #1;
            n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL stream_resp a%0d got %b exp 1", a, resp_valid); end
            n_cmp++; if (im_d !== pat(0, a) || neg_d !== pat(1, a) || pos_d !== pat(2, a)) begin
                n_err++; $display("FAIL stream_data a%0d got %h %h %h exp %h %h %h", a, im_d, neg_d, pos_d, pat(0, a), pat(1, a), pat(2, a));
            end
            n_cmp++; if (ce !== 1'b1 || saddr !== AW'((a + 1) % int'(NR))) begin n_err++; $display("FAIL stream_prefetch a%0d got ce %b addr %0d exp 1 %0d", a, ce, saddr, (a + 1) % int'(NR)); end
            cyc();
        end
    endtask

    task automatic test_wrap();
        // tag is now 0; jump to 30 costs one bubble, then 30,31,0 stream without bubbles
        req_addr = 8'd30;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wrap_bubble got %b exp 0", resp_valid); end
        cyc();
        for (int k = 0; k < 3; k++) begin
            int unsigned a;
            a = (k == 2) ? 0 : 30 + k;
            req_addr = AW'(a);
            #1;
            n_cmp++; if (resp_valid !== 1'b1 || im_d !== pat(0, a)) begin n_err++; $display("FAIL wrap_hit a%0d got %b %h exp 1 %h", a, resp_valid, im_d, pat(0, a)); end
            cyc();
        end
        for (int a = 1; a <= 5; a++) begin
            req_addr = AW'(a);
            cyc();
        end
        req_addr = 8'd0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL restart_bubble got %b exp 0", resp_valid); end
        cyc();
        n_cmp++; if (resp_valid !== 1'b1 || pos_d !== pat(2, 0)) begin n_err++; $display("FAIL restart_hit got %b %h exp 1 %h", resp_valid, pos_d, pat(2, 0)); end
        cyc();
    endtask

    task automatic test_stall();
        req_addr  = 8'd7;
        req_ready = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (resp_valid !== 1'b1 || neg_d !== pat(1, 7)) begin n_err++; $display("FAIL stall_hold k%0d got %b %h exp 1 %h", k, resp_valid, neg_d, pat(1, 7)); end
            n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL stall_ce k%0d got %b exp 0", k, ce); end
            cyc();
        end
        req_ready = 1'b1;
        #1;
        n_cmp++; if (ce !== 1'b1 || saddr !== 8'd8) begin n_err++; $display("FAIL stall_release got ce %b addr %0d exp 1 8", ce, saddr); end
        cyc();
        req_addr = 8'd8;
        #1;
        n_cmp++; if (resp_valid !== 1'b1 || im_d !== pat(0, 8)) begin n_err++; $display("FAIL stall_next got %b %h exp 1 %h", resp_valid, im_d, pat(0, 8)); end
        cyc();
    endtask

    task automatic test_contention();
        // tag is 9: request 9 together with a load
        req_addr   = 8'd9;
        load_valid = 1'b1;
        load_sel   = 2'd0;
        load_addr  = 8'd3;
        load_data  = '0;
        #1;
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL cont_ready got %b exp 0", load_ready); end
        n_cmp++; if (resp_valid !== 1'b1 || ce !== 1'b1 || we !== 3'b000 || saddr !== 8'd10) begin
            n_err++; $display("FAIL cont_read got v %b ce %b we %b addr %0d exp 1 1 000 10", resp_valid, ce, we, saddr);
        end
        cyc();
        req_valid = 1'b0;
        load_sel  = 2'd1;
        load_addr = 8'd20;
        load_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        n_cmp++; if (load_ready !== 1'b1 || ce !== 1'b1 || we !== 3'b010 || saddr !== 8'd20 || wdata !== 64'hDEAD_BEEF_0123_4567) begin
            n_err++; $display("FAIL inval_write got r %b ce %b we %b addr %0d wd %h", load_ready, ce, we, saddr, wdata);
        end
        cyc();
        load_valid = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 8'd10;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || ce !== 1'b1) begin n_err++; $display("FAIL inval_cold got v %b ce %b exp 0 1", resp_valid, ce); end
        cyc();
        n_cmp++; if (resp_valid !== 1'b1 || im_d !== pat(0, 10)) begin n_err++; $display("FAIL inval_hit got %b %h exp 1 %h", resp_valid, im_d, pat(0, 10)); end
        cyc();
        req_addr  = 8'd20;
        req_ready = 1'b0;
        cyc();
        n_cmp++; if (resp_valid !== 1'b1 || neg_d !== 64'hDEAD_BEEF_0123_4567 || im_d !== pat(0, 20)) begin
            n_err++; $display("FAIL loaded_row got %b %h %h exp 1 deadbeef01234567 %h", resp_valid, neg_d, im_d, pat(0, 20));
        end
        cyc();
        // dropped out-of-range load in HIT, then tag 20 must still hit at once
        req_valid  = 1'b0;
        load_valid = 1'b1;
        load_sel   = 2'd2;
        load_addr  = 8'd40;
        #1;
        n_cmp++; if (load_ready !== 1'b1 || ce !== 1'b0) begin n_err++; $display("FAIL drop_load got r %b ce %b exp 1 0", load_ready, ce); end
        cyc();
        load_valid = 1'b0;
        req_valid  = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b1 || neg_d !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL retain_hit got %b %h exp 1", resp_valid, neg_d); end
        cyc();
    endtask

    task automatic test_error();
        req_addr = 8'd40;
        #1;
        n_cmp++; if (ce !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL err_req got ce %b v %b exp 0 0", ce, resp_valid); end
        cyc();
        n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL err_set got %b exp 1", addr_err); end
        req_valid = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", addr_err); end
        req_valid = 1'b1;
        req_addr  = 8'd20;
        #1;
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL err_tag_kept got %b exp 1", resp_valid); end
    endtask

    task automatic test_reset_mid();
        req_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || ce !== 1'b0 || we !== 3'b000 || saddr !== '0) begin
            n_err++; $display("FAIL midreset_out got v %b ce %b we %b addr %0d exp 0 0 000 0", resp_valid, ce, we, saddr);
        end
        n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL midreset_err got %b exp 0", addr_err); end
        cyc();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || ce !== 1'b1 || saddr !== 8'd20) begin n_err++; $display("FAIL postreset_cold got v %b ce %b addr %0d exp 0 1 20", resp_valid, ce, saddr); end
        cyc();
        n_cmp++; if (resp_valid !== 1'b1 || im_d !== pat(0, 20)) begin n_err++; $display("FAIL postreset_hit got %b %h exp 1 %h", resp_valid, im_d, pat(0, 20)); end
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_load();
        test_stream();
        test_wrap();
        test_stall();
        test_contention();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
